moo_ctr_gen: RTL

MOO_CTR_GEN -- requirements
Module: moo_ctr_gen

---
 rtl/moo_ctr_gen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/moo_ctr_gen.sv
// moo_ctr_gen: block-feed generator for an AES mode-of-operation datapath.
// Holds the working block (counter, chaining value or GHASH seed) and
// presents it to the AES core. Counter modes advance the counter field on
// each accepted block; feedback modes wait for the next chaining value.
module moo_ctr_gen (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_core,
    input  logic         iv_ld,
    input  logic [127:0] iv,
    input  logic [3:0]   moo_op,
    input  logic [7:0]   ccm_b0,
    input  logic         blk_rdy,
    input  logic         fb_vld,
    input  logic [127:0] fb_dat,
    output logic         blk_vld,
    output logic [127:0] blk_dat,
    output logic [15:0]  blk_cnt,
    output logic         ctr_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_WAIT_FB = 2'd2
    } state_t;

    localparam logic [2:0] MODE_CMAC = 3'b000;
    localparam logic [2:0] MODE_ECB  = 3'b001;
    localparam logic [2:0] MODE_CBC  = 3'b010;
    localparam logic [2:0] MODE_OFB  = 3'b011;
    localparam logic [2:0] MODE_CFB  = 3'b100;
    localparam logic [2:0] MODE_CTR  = 3'b101;
    localparam logic [2:0] MODE_CCM  = 3'b110;
    localparam logic [2:0] MODE_GCM  = 3'b111;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t         state_q, state_d;
    logic [3:0]     mode_q, mode_d;      // [3] = decrypt, kept for software only
    logic [2:0]     q_q, q_d;            // CCM q field
    logic [127:0]   wreg_q, wreg_d;
    logic           blk_vld_q, blk_vld_d;
    logic [15:0]    blk_cnt_q, blk_cnt_d;
    logic           ctr_ovf_q, ctr_ovf_d;

    // CCM counter field masks, one per q value; q=0 behaves as q=1 (16 bits)
    logic [127:0]   ccm_mask_tbl [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ccm_mask
            localparam int FW = (gi == 0) ? 16 : 8 * (gi + 1);
            assign ccm_mask_tbl[gi] = {{(128 - FW){1'b0}}, {FW{1'b1}}};
        end
    endgenerate

    logic [2:0]     mode_sel;
    logic           is_ctr_mode;
    logic           is_fb_mode;
    logic [127:0]   ctr_mask;
    logic           ctr_full;
    logic [127:0]   wreg_inc;
    logic           xfer;

    assign mode_sel = mode_q[2:0];
    assign xfer     = blk_vld_q & blk_rdy;

    // Select the counter field for the latched mode and form its increment
    always_comb begin
        is_ctr_mode = 1'b0;
        is_fb_mode  = 1'b0;
        ctr_mask    = '0;
        unique case (mode_sel)
            MODE_CTR: begin
                is_ctr_mode = 1'b1;
                ctr_mask    = '1;
            end
            MODE_GCM: begin
                is_ctr_mode = 1'b1;
                ctr_mask    = {96'd0, 32'hFFFF_FFFF};
            end
            MODE_CCM: begin
                is_ctr_mode = 1'b1;
                ctr_mask    = ccm_mask_tbl[q_q];
            end
            MODE_CBC, MODE_OFB, MODE_CFB: begin
                is_fb_mode  = 1'b1;
            end
            MODE_CMAC, MODE_ECB: begin
                is_ctr_mode = 1'b0;
            end
            default: begin
                is_ctr_mode = 1'b0;
            end
        endcase
        ctr_full = ((wreg_q & ctr_mask) == ctr_mask);
        // Carry out of the field is dropped by the mask; upper bits are kept
        wreg_inc = (wreg_q & ~ctr_mask) | ((wreg_q + 128'd1) & ctr_mask);
    end

    // Next-state logic: clear beats load, load beats transfer/feedback
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        q_d       = q_q;
        wreg_d    = wreg_q;
        blk_cnt_d = blk_cnt_q;
        ctr_ovf_d = ctr_ovf_q;

        if (clr_core) begin
            state_d   = ST_IDLE;
            mode_d    = '0;
            q_d       = '0;
            wreg_d    = '0;
            blk_cnt_d = '0;
            ctr_ovf_d = 1'b0;
        end else if (iv_ld) begin
            state_d   = ST_ARMED;
            mode_d    = moo_op;
            q_d       = ccm_b0[2:0];
            wreg_d    = iv;
            blk_cnt_d = '0;
            ctr_ovf_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED: begin
                    if (xfer) begin
                        if (blk_cnt_q != CNT_MAX) begin
                            blk_cnt_d = blk_cnt_q + 16'd1;
                        end
                        if (is_ctr_mode) begin
                            wreg_d = wreg_inc;
                            if (ctr_full) begin
                                ctr_ovf_d = 1'b1;
                            end
                        end else if (is_fb_mode) begin
                            state_d = ST_WAIT_FB;
                        end
                    end
                end
                ST_WAIT_FB: begin
                    if (fb_vld) begin
                        wreg_d  = fb_dat;
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Registered valid tracks the state being entered
        blk_vld_d = (state_d == ST_ARMED);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= '0;
            q_q       <= '0;
            wreg_q    <= '0;
            blk_vld_q <= 1'b0;
            blk_cnt_q <= '0;
            ctr_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            q_q       <= q_d;
            wreg_q    <= wreg_d;
            blk_vld_q <= blk_vld_d;
            blk_cnt_q <= blk_cnt_d;
            ctr_ovf_q <= ctr_ovf_d;
        end
    end

    assign blk_vld = blk_vld_q;
    assign blk_dat = wreg_q;
    assign blk_cnt = blk_cnt_q;
    assign ctr_ovf = ctr_ovf_q;

endmodule
